// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared keypad codes and key_scan FSM encoding
package clock_pkg;

    localparam int KEY_COUNT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_MANY = 2'd2
    } key_state_e;

    // Scan index row*4+col to the legend printed on the Pmod KYPD
    function automatic logic [3:0] kypd_legend(input logic [3:0] idx);
        case (idx)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'h0;
            4'd13:   return 4'hF;
            4'd14:   return 4'hE;
            default: return 4'hD;
        endcase
    endfunction

    function automatic key_state_e key_class(input logic [KEY_COUNT-1:0] m);
        int cnt;
        cnt = $countones(m);
        if (cnt == 0)      return ST_IDLE;
        else if (cnt == 1) return ST_ONE;
        else               return ST_MANY;
    endfunction

    function automatic logic [3:0] key_index(input logic [KEY_COUNT-1:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous level inputs
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - 4x4 keypad row scanner with frame debounce and single-key event FSM
module key_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] nCOL,
    output logic [3:0] nROW,
    output logic [3:0] KEY,
    output logic       KEYVALID,
    output logic       KEYDOWN,
    output logic       MULTI
);

    localparam int             CW         = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [7:0]     STABLE_MAX = 8'(DEB_SCANS);

    logic [3:0]    ncol_sync;
    logic [3:0]    col;
    logic [CW-1:0] dwell_q;
    logic [1:0]    row_q;
    logic [15:0]   snap_q;
    logic [15:0]   prev_q;
    logic [15:0]   accepted_q;
    logic [7:0]    stable_q;
    logic [7:0]    stable_d;
    logic          cmp_q;
    logic [3:0]    key_q;
    logic          keyvalid_q;
    logic          last_dwell;
    logic          accept;
    logic          pulse;
    key_state_e    snap_class;
    key_state_e    state_q;
    key_state_e    state_d;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (nCOL),
        .q_o   (ncol_sync)
    );

    assign col        = ~ncol_sync;
    assign last_dwell = (dwell_q == DWELL_LAST);
    assign nROW       = ~(4'b0001 << row_q);
    assign snap_class = key_class(snap_q);

    always_comb begin
        stable_d = 8'd1;
        if (snap_q == prev_q) begin
            stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 8'd1;
        end
    end

    assign accept = cmp_q && (stable_d >= STABLE_MAX) && (snap_q != accepted_q);

    // cmp_q marks the cycle after row 3 is sampled, when the snapshot is complete
    always_ff @(posedge CLK) begin
        if (RST) begin
            dwell_q    <= '0;
            row_q      <= 2'd0;
            snap_q     <= '0;
            prev_q     <= '0;
            accepted_q <= '0;
            stable_q   <= '0;
            cmp_q      <= 1'b0;
            key_q      <= 4'd0;
            keyvalid_q <= 1'b0;
        end else begin
            keyvalid_q <= 1'b0;
            cmp_q      <= last_dwell && (row_q == 2'd3);
            if (last_dwell) begin
                dwell_q                    <= '0;
                row_q                      <= row_q + 2'd1;
                snap_q[{row_q, 2'b00} +: 4] <= col;
            end else begin
                dwell_q <= dwell_q + 1'b1;
            end
            if (cmp_q) begin
                stable_q <= stable_d;
                prev_q   <= snap_q;
            end
            if (accept) begin
                accepted_q <= snap_q;
                if (pulse) begin
                    key_q      <= key_index(snap_q);
                    keyvalid_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Leaving MANY for ONE stays silent so a chord release cannot fake a press
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        if (accept) begin
            state_d = snap_class;
            pulse   = (snap_class == ST_ONE) && (state_q != ST_MANY);
        end
    end

    always_comb begin
        KEYDOWN = (state_q == ST_ONE);
        MULTI   = (state_q == ST_MANY);
    end

    assign KEY      = key_q;
    assign KEYVALID = keyvalid_q;

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - randomized and directed bench for key_scan against a frame-level model
module tb_key_scan;

    localparam int SD    = 8;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SD;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] nCOL;
    logic [3:0] nROW;
    logic [3:0] KEY;
    logic       KEYVALID;
    logic       KEYDOWN;
    logic       MULTI;
    logic [15:0] held = '0;

    int checks   = 0;
    int failures = 0;

    logic [15:0] hist [0:4095];
    logic [15:0] frames [$];
    logic [15:0] accepted;
    logic [3:0]  exp_key;
    logic        exp_valid, exp_down, exp_multi;

    int          npulse, pulse_cyc, saw_multi;
    logic [3:0]  pulse_key, first_key;
    logic [15:0] rnd_mat;
    int          rnd_next;

    key_scan #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .nCOL     (nCOL),
        .nROW     (nROW),
        .KEY      (KEY),
        .KEYVALID (KEYVALID),
        .KEYDOWN  (KEYDOWN),
        .MULTI    (MULTI)
    );

    always #5 CLK = ~CLK;

    // Keypad: a held key shorts its column to the active (low) row
    always_comb begin
        nCOL = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!nROW[r] && held[r*4+c]) nCOL[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        frames.delete();
        frames.push_back(16'h0);
        accepted  = '0;
        exp_key   = 4'd0;
        exp_valid = 1'b0;
        exp_down  = 1'b0;
        exp_multi = 1'b0;
    endtask

    // A frame is accepted once the last DEB frames (reset counts as an empty frame) agree
    task automatic model_frame(input int f);
        logic [15:0] snap;
        logic        stable;
        int          newcnt, oldcnt;
        snap = '0;
        for (int r = 0; r < 4; r++)
            snap[r*4 +: 4] = hist[f*FRAME + r*SD + SD - 3][r*4 +: 4];
        frames.push_back(snap);
        if (frames.size() > DEB) void'(frames.pop_front());
        stable = (frames.size() == DEB);
        foreach (frames[i]) if (frames[i] != snap) stable = 1'b0;
        if (stable && snap != accepted) begin
            newcnt = $countones(snap);
            oldcnt = $countones(accepted);
            if (newcnt == 1 && oldcnt <= 1) begin
                exp_valid = 1'b1;
                for (int i = 0; i < 16; i++) if (snap[i]) exp_key = 4'(i);
            end
            accepted  = snap;
            exp_down  = (newcnt == 1);
            exp_multi = (newcnt >= 2);
        end
    endtask

    function automatic logic [15:0] stim(input int mode, input int n);
        case (mode)
            1: return (n < 200) ? 16'h0200 : 16'h0;
            2: return (n < 64 && ((n / 10) % 2 == 1)) ? 16'h0 : 16'h0008;
            3: return (n < 200) ? 16'h8010 : (n < 350) ? 16'h0010 : 16'h0;
            4: return (n < 200) ? 16'h0001 : (n < 400) ? 16'h0002 : 16'h0;
            5: return 16'h0020;
            default: return 16'h0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic run(input int mode, input int ncyc);
        logic [3:0] erow;
        npulse    = 0;
        pulse_cyc = -1;
        saw_multi = 0;
        pulse_key = 4'd0;
        first_key = 4'd0;
        for (int n = 0; n < ncyc; n++) begin
            if (n > 0) @(negedge CLK);
            if (mode == 6) begin
                if (n == 0 || n >= rnd_next) begin
                    rnd_mat = '0;
                    repeat ($urandom_range(0, 3)) rnd_mat[$urandom_range(0, 15)] = 1'b1;
                    rnd_next = n + $urandom_range(16, 200);
                end
                held = rnd_mat;
            end else begin
                held = stim(mode, n);
            end
            hist[n] = held;
            erow = ~(4'b0001 << ((n / SD) % 4));
            check("nROW", 32'(nROW), 32'(erow));
            check("KEYVALID", 32'(KEYVALID), 32'(exp_valid));
            check("KEY", 32'(KEY), 32'(exp_key));
            check("KEYDOWN", 32'(KEYDOWN), 32'(exp_down));
            check("MULTI", 32'(MULTI), 32'(exp_multi));
            if (KEYVALID) begin
                if (npulse == 0) begin
                    pulse_cyc = n;
                    first_key = KEY;
                end
                npulse++;
                pulse_key = KEY;
            end
            if (MULTI) saw_multi = 1;
            exp_valid = 1'b0;
            if (n >= FRAME && n % FRAME == 0) model_frame(n / FRAME - 1);
        end
    endtask

    initial begin
        do_reset();
        run(0, 200);
        check("idle_pulses", 32'(npulse), 0);

        do_reset();
        run(1, 400);
        check("hold_pulses", 32'(npulse), 1);
        check("hold_key", 32'(pulse_key), 9);
        check("hold_cycle", 32'(pulse_cyc), 97);

        do_reset();
        run(2, 300);
        check("bounce_pulses", 32'(npulse), 1);
        check("bounce_key", 32'(pulse_key), 3);

        do_reset();
        run(3, 500);
        check("multi_pulses", 32'(npulse), 0);
        check("multi_seen", 32'(saw_multi), 1);
        check("multi_key", 32'(KEY), 0);

        do_reset();
        run(4, 550);
        check("slide_pulses", 32'(npulse), 2);
        check("slide_first", 32'(first_key), 0);
        check("slide_last", 32'(pulse_key), 1);

        do_reset();
        run(5, 150);
        check("pre_rst_down", 32'(KEYDOWN), 1);
        do_reset();
        run(5, 150);
        check("rst_pulses", 32'(npulse), 1);
        check("rst_key", 32'(pulse_key), 5);
        check("rst_cycle", 32'(pulse_cyc), 97);

        do_reset();
        run(6, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
